// File: rtl/disp_sched.sv
// disp_sched -- round-robin owner scheduler for the shared 8-digit
// seven-segment scan unit.
//
// Two requesters compete for the display. An owner keeps the display for at
// least DWELL_TICKS cycles before a waiting competitor may preempt it. An
// owner that drops its request releases the display at once. Ties are broken
// in favour of the requester that did not own the display last.
//
// Optional build macro: DISP_SCHED_GAP_EN
//   When defined, every owner switch and every release passes through a blank
//   GAP interval of GAP_TICKS cycles. During the gap nothing is granted and
//   the display is driven to zero, which avoids ghosting on the LEDs.
//   When undefined, switches are direct and no gap counter exists.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   req0     in   requester 0 wants the display (level)
//   data0    in   requester 0 digits, nibble 0 = rightmost digit
//   req1     in   requester 1 wants the display (level)
//   data1    in   requester 1 digits
//   gnt0     out  requester 0 owns the display (registered)
//   gnt1     out  requester 1 owns the display (registered)
//   display  out  word forwarded to the scan unit (registered)
//   disp_en  out  scan-unit enable, equals gnt0 | gnt1 (registered)
module disp_sched #(
  parameter logic [31:0] DWELL_TICKS = 32'd50_000_000,
  parameter int          CNT_WIDTH   = 32,
  parameter logic [31:0] GAP_TICKS   = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] display,
  output logic        disp_en
);

  localparam int DATA_W = 32;

  // A dwell of 0 behaves like 1: the owner is guaranteed one cycle.
  localparam logic [31:0]          DWELL_EFF = (DWELL_TICKS == 32'd0) ? 32'd1 : DWELL_TICKS;
  localparam logic [CNT_WIDTH-1:0] DWELL_MAX = CNT_WIDTH'(DWELL_EFF - 32'd1);

`ifdef DISP_SCHED_GAP_EN
  localparam logic [31:0]          GAP_EFF = (GAP_TICKS == 32'd0) ? 32'd1 : GAP_TICKS;
  localparam logic [CNT_WIDTH-1:0] GAP_MAX = CNT_WIDTH'(GAP_EFF - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2,
    S_GAP  = 2'd3
  } state_t;
`else
  // GAP_TICKS only matters when the blank interval is compiled in.
  localparam logic [31:0] unused_gap_ticks = GAP_TICKS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;
`endif

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
`ifdef DISP_SCHED_GAP_EN
  logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
`endif
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic                 disp_en_q, disp_en_d;
  logic [DATA_W-1:0]    display_q, display_d;

  // Dwell counter increment that stops at the preemption threshold.
  function automatic logic [CNT_WIDTH-1:0] dwell_sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (c == DWELL_MAX) return c;
    return c + CNT_WIDTH'(1);
  endfunction

  // Arbitration from an unowned state; on a tie the requester that did not
  // own the display last wins.
  function automatic state_t arbitrate(input logic r0, input logic r1, input logic lst);
    if (r0 && r1) return lst ? S_OWN0 : S_OWN1;
    if (r0)       return S_OWN0;
    if (r1)       return S_OWN1;
    return S_IDLE;
  endfunction

  // Next-state / control
  always_comb begin
    logic leave;
    state_d     = state_q;
    last_d      = last_q;
    dwell_cnt_d = dwell_cnt_q;
`ifdef DISP_SCHED_GAP_EN
    gap_cnt_d   = gap_cnt_q;
`endif
    leave       = 1'b0;

    case (state_q)
      S_IDLE: state_d = arbitrate(req0, req1, last_q);

      S_OWN0: begin
        if (!req0) begin
          leave   = 1'b1;
          state_d = req1 ? S_OWN1 : S_IDLE;
        end else if (req1 && (dwell_cnt_q == DWELL_MAX)) begin
          leave   = 1'b1;
          state_d = S_OWN1;
        end else begin
          dwell_cnt_d = dwell_sat_inc(dwell_cnt_q);
        end
        if (leave) last_d = 1'b0;
      end

      S_OWN1: begin
        if (!req1) begin
          leave   = 1'b1;
          state_d = req0 ? S_OWN0 : S_IDLE;
        end else if (req0 && (dwell_cnt_q == DWELL_MAX)) begin
          leave   = 1'b1;
          state_d = S_OWN0;
        end else begin
          dwell_cnt_d = dwell_sat_inc(dwell_cnt_q);
        end
        if (leave) last_d = 1'b1;
      end

`ifdef DISP_SCHED_GAP_EN
      S_GAP: begin
        if (gap_cnt_q == GAP_MAX) state_d = arbitrate(req0, req1, last_q);
        else                      gap_cnt_d = gap_cnt_q + CNT_WIDTH'(1);
      end
`endif

      default: state_d = S_IDLE;
    endcase

    if (leave) begin
      dwell_cnt_d = '0;
`ifdef DISP_SCHED_GAP_EN
      // Every exit from ownership is routed through the blank interval.
      state_d   = S_GAP;
      gap_cnt_d = '0;
`endif
    end
  end

  // Registered outputs, decoded from the next state so a grant appears one
  // cycle after the request is sampled.
  always_comb begin
    gnt0_d    = (state_d == S_OWN0);
    gnt1_d    = (state_d == S_OWN1);
    disp_en_d = gnt0_d | gnt1_d;
    display_d = display_q;
    case (state_d)
      S_OWN0:  display_d = data0;
      S_OWN1:  display_d = data1;
`ifdef DISP_SCHED_GAP_EN
      S_GAP:   display_d = '0;
`endif
      default: display_d = display_q;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      dwell_cnt_q <= '0;
`ifdef DISP_SCHED_GAP_EN
      gap_cnt_q   <= '0;
`endif
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      disp_en_q   <= 1'b0;
      display_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      dwell_cnt_q <= dwell_cnt_d;
`ifdef DISP_SCHED_GAP_EN
      gap_cnt_q   <= gap_cnt_d;
`endif
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      disp_en_q   <= disp_en_d;
      display_q   <= display_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign disp_en = disp_en_q;
  assign display = display_q;

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched -- directed self-checking bench for disp_sched with
// DWELL_TICKS=4 and GAP_TICKS=2. Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at the same point.
module tb_disp_sched;

  logic        clk;
  logic        rst;
  logic        req0;
  logic [31:0] data0;
  logic        req1;
  logic [31:0] data1;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] display;
  logic        disp_en;

  int n_cmp = 0;
  int n_err = 0;

  disp_sched #(
    .DWELL_TICKS(32'd4),
    .CNT_WIDTH  (32),
    .GAP_TICKS  (32'd2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .data0  (data0),
    .req1   (req1),
    .data1  (data1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .display(display),
    .disp_en(disp_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Check all outputs against the expected grant pair and display word.
  task automatic check_out(input string tag, input logic e_g0, input logic e_g1,
                           input logic [31:0] e_disp);
    chk({tag, "_gnt0"}, {31'd0, gnt0}, {31'd0, e_g0});
    chk({tag, "_gnt1"}, {31'd0, gnt1}, {31'd0, e_g1});
    chk({tag, "_en"},   {31'd0, disp_en}, {31'd0, e_g0 | e_g1});
    chk({tag, "_disp"}, display, e_disp);
  endtask

  initial begin
    logic [31:0] d;
    rst   = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 32'h1234_5678;
    data1 = 32'h0000_0042;

    // Reset held two cycles with both requesting
    tick();
    tick();
    check_out("reset", 1'b0, 1'b0, 32'h0);

    // Release: requester 0 wins the first tie
    rst = 1'b0;
    tick();
    check_out("first_gnt", 1'b1, 1'b0, 32'h1234_5678);

`ifdef DISP_SCHED_GAP_EN
    // Owner 0 keeps the display through its dwell
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("gap_dwell0", 1'b1, 1'b0, 32'h1234_5678);
    end
    // Preemption passes through exactly two blank cycles
    tick();
    check_out("gap_blank0", 1'b0, 1'b0, 32'h0);
    tick();
    check_out("gap_blank1", 1'b0, 1'b0, 32'h0);
    tick();
    check_out("gap_own1", 1'b0, 1'b1, 32'h0000_0042);
`else
    // req1 waits; owner 0 holds until dwell reaches 3, then preempted
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("dwell0", 1'b1, 1'b0, 32'h1234_5678);
    end
    tick();
    check_out("preempt", 1'b0, 1'b1, 32'h0000_0042);

    // Owner 1 releases at dwell_cnt=1 with req0 waiting
    tick();
    check_out("own1_d1", 1'b0, 1'b1, 32'h0000_0042);
    req1 = 1'b0;
    tick();
    check_out("release1", 1'b1, 1'b0, 32'h1234_5678);

    // Sole requester: continuous grant, display follows data0 with 1-cycle lag
    for (int i = 0; i < 20; i++) begin
      d     = 32'hA000_0000 + 32'(i);
      data0 = d;
      tick();
      check_out("track", 1'b1, 1'b0, d);
    end

    // Release to IDLE: display keeps its last value
    req0 = 1'b0;
    tick();
    check_out("idle_hold", 1'b0, 1'b0, 32'hA000_0013);

    // One-cycle request pulse still yields a one-cycle grant
    req1 = 1'b1;
    tick();
    check_out("pulse_gnt", 1'b0, 1'b1, 32'h0000_0042);
    req1 = 1'b0;
    tick();
    check_out("pulse_rel", 1'b0, 1'b0, 32'h0000_0042);

    // Requester 0 owns, drops, then reasserts with requester 1: loses the tie
    req0 = 1'b1;
    tick();
    check_out("own0_again", 1'b1, 1'b0, 32'hA000_0013);
    req0 = 1'b0;
    tick();
    check_out("drop0", 1'b0, 1'b0, 32'hA000_0013);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    check_out("tie_lost", 1'b0, 1'b1, 32'h0000_0042);

    // Reset in the middle of OWN1
    rst = 1'b1;
    tick();
    check_out("mid_reset", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    check_out("post_reset", 1'b1, 1'b0, 32'hA000_0013);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
- Time-shares the single 8-digit seven-segment scan unit between two requesters (for example, a status source and a debug source).
- Performs round-robin arbitration with a guaranteed minimum dwell time per owner.
- Drives the 32-bit display word and the enable of the downstream scan unit.
- Sits between the producer logic and the LED scan controller.

Parameters:
- DWELL_TICKS, 32'd50_000_000: minimum cycles an owner keeps the display before it can be preempted. A value of 0 is treated as 1.
- CNT_WIDTH, 32: width of the dwell counter and the gap counter.
- GAP_TICKS, 32'd1000: blank cycles inserted between owners. Used only when DISP_SCHED_GAP_EN is defined.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 wants the display (level, held while it wants it)
- data0  input  32  requester 0's eight 4-bit digits; nibble 0 = rightmost digit
- req1  input  1  requester 1 wants the display
- data1  input  32  requester 1's digits
- gnt0  output  1  requester 0 currently owns the display
- gnt1  output  1  requester 1 currently owns the display
- display  output  32  word forwarded to the scan unit
- disp_en  output  1  enable to the scan unit; 1 only while an owner is granted

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values (applied at the first clk edge with rst=1, including mid-operation):
  - state=IDLE, gnt0=0, gnt1=0, display=32'h0, disp_en=0
  - dwell_cnt=0, gap_cnt=0
  - last=1, so requester 0 wins the first tie
- States: IDLE, OWN0, OWN1, plus GAP when the macro is enabled.
- IDLE:
  - Only req0 high: go to OWN0.
  - Only req1 high: go to OWN1.
  - Both high: grant the requester != last.
  - Neither high: stay in IDLE.
  - Latency: the grant is visible one cycle after req is sampled.
- OWNx (x = 0 or 1):
  - gntx=1 and disp_en=1.
  - display <= datax every cycle, so owner data changes propagate with 1-cycle latency.
  - dwell_cnt increments each cycle and saturates at DWELL_TICKS-1.
- Transitions out of OWNx, in priority order:
  - reqx=0: release immediately. Go to OWNy if reqy=1, otherwise IDLE. Dwell does not matter.
  - reqx=1, dwell_cnt==DWELL_TICKS-1 and reqy=1: preempt and go to OWNy.
  - Otherwise: stay in OWNx. A saturated dwell with no competitor holds ownership indefinitely.
- On leaving OWNx: last <= x and dwell_cnt <= 0.
- Entering IDLE: gnt0=0, gnt1=0, disp_en=0, and display keeps its last value.
- Invariant: gnt0 and gnt1 are never both 1. disp_en == (gnt0 | gnt1).
- Boundary conditions:
  - A req pulse of 1 cycle still yields a grant of at least 1 cycle. It is released on the next evaluation.
  - A requester that drops and reasserts while the other is waiting loses the tie, because last has updated.

Optional Feature:
- Macro: DISP_SCHED_GAP_EN.
- Defined: every owner switch (OWNx to OWNy) and every release to IDLE passes through GAP.
  - In GAP: gnt0=0, gnt1=0, disp_en=0, display=32'h0.
  - GAP lasts GAP_TICKS cycles (minimum 1), using gap_cnt.
  - After GAP, arbitrate as in IDLE with the updated last.
  - Purpose: prevents ghosting on the LEDs between content changes.
- Not defined: no GAP state, gap_cnt is absent, and switches are direct as described above.

Test Plan (DWELL_TICKS=4, GAP_TICKS=2 unless stated):
- Reset with rst=1 for 2 cycles while req0=req1=1 -> all outputs 0. Release rst -> gnt0=1 one cycle later, display=data0=32'h1234_5678, disp_en=1.
- req0 held, req1 raised at cycle 1 of ownership -> gnt0 stays high until dwell_cnt reaches 3. The next cycle has gnt1=1 and display=data1=32'h0000_0042.
- Requester 1 owns and req1 drops at dwell_cnt=1 with req0=1 -> gnt1=0 and gnt0=1 on the following edge. Never both high.
- Only req0=1 for 20 cycles -> gnt0 is continuous and display tracks data0 changes with 1-cycle lag.
- rst asserted mid-OWN1 -> next edge has gnt1=0, disp_en=0, display=0. After release with both requesting, gnt0 wins (last reset to 1).
- With DISP_SCHED_GAP_EN defined, preemption from OWN0 to OWN1 -> exactly 2 cycles of gnt=00, disp_en=0, display=0, then gnt1=1.
